// File: rtl/lm_led_sequencer_pkg.sv
// Shared constants for the LED sequencer: FSM encoding, counter widths and default timings.
// Pure definitions, no logic.
package LM_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam int SHOWN_CNT_W      = 16;
   localparam int WIDTH_LEDS       = 8;
   localparam int HOLD_CYCLES_DEF  = 1000;
   localparam int BLINK_CYCLES_DEF = 500;

   function automatic int lm_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lm_led_sequencer_hold_timer.sv
// Load/decrement down-counter; expired is high while the count is zero.
// Priority: rst > clr > load > dec; decrementing stops at zero.
module LM_hold_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign expired = (cnt_q == '0);

endmodule

// File: rtl/lm_led_sequencer.sv
// Pops LED patterns from the LM FIFO and shows each for HOLD_CYCLES; leds follow a pop by two edges.
// Optional per-bit blinking during the hold is built when LM_BLINK_EN is defined.
module lm_led_sequencer
   import LM_pkg::*;
#(
   parameter int WIDTH          = WIDTH_LEDS,
   parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
   parameter int CLEAR_ON_EMPTY = 1,
   parameter int BLINK_CYCLES   = BLINK_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       rd_data,
   input  logic                   fifo_empty,
   input  logic [WIDTH-1:0]       blink_mask,
   input  logic                   flush,
   output logic                   rd_en,
   output logic [WIDTH-1:0]       leds,
   output logic                   busy,
   output logic [SHOWN_CNT_W-1:0] shown_cnt
);

   localparam int               CNT_W     = $clog2(lm_max(HOLD_CYCLES, BLINK_CYCLES) + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [1:0]             state_q, state_d;
   logic [WIDTH-1:0]       leds_reg_q, leds_reg_d;
   logic [SHOWN_CNT_W-1:0] shown_q, shown_d;
   logic                   hold_load, hold_dec, hold_expired;
   logic [CNT_W-1:0]       hold_cnt_unused;

   always_comb begin
      state_d    = state_q;
      leds_reg_d = leds_reg_q;
      shown_d    = shown_q;
      hold_load  = 1'b0;
      hold_dec   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_READ;
         end
         ST_READ: state_d = ST_LATCH;
         ST_LATCH: begin
            leds_reg_d = rd_data;
            hold_load  = 1'b1;
            if (shown_q != '1) shown_d = shown_q + 1'b1;
            state_d    = ST_HOLD;
         end
         default: begin
            if (hold_expired) begin
               if (!fifo_empty) begin
                  state_d = ST_READ;
               end else begin
                  state_d = ST_IDLE;
                  if (CLEAR_ON_EMPTY != 0) leds_reg_d = '0;
               end
            end else begin
               hold_dec = 1'b1;
            end
         end
      endcase
      // A pop already in flight is dropped: its data is never latched.
      if (flush) begin
         state_d    = ST_IDLE;
         leds_reg_d = '0;
         shown_d    = shown_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         leds_reg_q <= '0;
         shown_q    <= '0;
      end else begin
         state_q    <= state_d;
         leds_reg_q <= leds_reg_d;
         shown_q    <= shown_d;
      end
   end

   LM_hold_timer #(.CNT_W(CNT_W)) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .load     (hold_load),
      .load_val (HOLD_LOAD),
      .dec      (hold_dec),
      .cnt      (hold_cnt_unused),
      .expired  (hold_expired)
   );

   assign rd_en     = (state_q == ST_READ);
   assign busy      = (state_q != ST_IDLE);
   assign shown_cnt = shown_q;

`ifdef LM_BLINK_EN
   localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_CYCLES - 1);

   logic [WIDTH-1:0] mask_q, mask_d;
   logic             phase_off_q, phase_off_d;
   logic             blink_load, blink_dec, blink_expired;
   logic [CNT_W-1:0] blink_cnt_unused;

   // Phase only advances while the hold is still running; any other state forces "on".
   always_comb begin
      mask_d      = mask_q;
      phase_off_d = 1'b0;
      blink_load  = 1'b0;
      blink_dec   = 1'b0;
      if (state_q == ST_LATCH) begin
         mask_d     = blink_mask;
         blink_load = 1'b1;
      end else if ((state_q == ST_HOLD) && !hold_expired) begin
         if (blink_expired) begin
            blink_load  = 1'b1;
            phase_off_d = ~phase_off_q;
         end else begin
            blink_dec   = 1'b1;
            phase_off_d = phase_off_q;
         end
      end
      if (flush) phase_off_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q      <= '0;
         phase_off_q <= 1'b0;
      end else begin
         mask_q      <= mask_d;
         phase_off_q <= phase_off_d;
      end
   end

   LM_hold_timer #(.CNT_W(CNT_W)) u_blink_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .load     (blink_load),
      .load_val (BLINK_LOAD),
      .dec      (blink_dec),
      .cnt      (blink_cnt_unused),
      .expired  (blink_expired)
   );

   assign leds = leds_reg_q & ~(mask_q & {WIDTH{phase_off_q}});
`else
   logic blink_mask_unused;
   assign blink_mask_unused = ^blink_mask;
   assign leds = leds_reg_q;
`endif

endmodule

// File: doc/lm_led_sequencer.md
# lm_led_sequencer

Parametrised LED-manager decoder. It pops LED patterns from the LM FIFO read port, shows each pattern for a programmable minimum hold time, and optionally blinks selected bits. When the FIFO runs dry it clears the display or keeps the last pattern, as configured. It sits between the LM FIFO and the board LED pins and supersedes the single-cycle pass-through decoder.

## Interface
- WIDTH, default WIDTH_LEDS (8): LED/pattern width.
- HOLD_CYCLES, default 1000: cycles each pattern stays in HOLD; legal range ≥1.
- CLEAR_ON_EMPTY, default 1: 1 means LEDs go to 0 when the FIFO is found empty after a hold; 0 means the last pattern is kept.
- BLINK_CYCLES, default 500: half-period of blink, in cycles; ≥1. Used only with LM_BLINK_EN.
- CNT_W, default $clog2(max(HOLD_CYCLES,BLINK_CYCLES)+1): counter width; derived, not overridden.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_data  in  WIDTH  FIFO read data; valid in the cycle after an rd_en cycle.
- fifo_empty  in  1  FIFO empty flag.
- blink_mask  in  WIDTH  bits to blink; sampled together with rd_data. Present in both builds; ignored without LM_BLINK_EN.
- flush  in  1  synchronous abort-and-clear.
- rd_en  out  1  FIFO pop strobe; one cycle per pattern.
- leds  out  WIDTH  registered LED drive.
- busy  out  1  high in READ, LATCH, HOLD.
- shown_cnt  out  16  patterns latched since reset; saturates at 0xFFFF.

## Operation
- FSM states:
  - IDLE: if fifo_empty is low, go to READ.
  - READ: rd_en=1; go to LATCH.
  - LATCH: leds_reg←rd_data, mask_reg←blink_mask, hold counter←HOLD_CYCLES-1, shown_cnt++ (saturating); go to HOLD.
  - HOLD: counter decrements each edge. When the counter is 0: if fifo_empty is low, go to READ; otherwise go to IDLE, with leds_reg←0 if CLEAR_ON_EMPTY=1.
- rd_en is a Moore decode of READ only. This block is the FIFO's only reader, so fifo_empty cannot rise between IDLE and the READ pop.
- flush (any state): state←IDLE, leds_reg←0, counters←0. A pop already issued in READ is discarded. shown_cnt is not changed.
- rst has priority over flush. Reset values: state IDLE, leds 0, rd_en 0, busy 0, shown_cnt 0, blink phase "on".
- Reset mid-operation: any popped-but-unlatched word is lost. This is accepted.

## Timing
- IDLE samples fifo_empty=0 at edge k. rd_en is high for cycle k..k+1. leds update at edge k+2.
- Back-to-back patterns: leds change every HOLD_CYCLES+2 cycles.
- Clear on empty: leds go to 0 at the same edge that HOLD exits with the counter at 0.
- flush asserted before edge k: leds=0 and state=IDLE after edge k. A new READ can start at edge k+1 at the earliest.

## Configuration
- LM_BLINK_EN defined:
  - A blink counter counts BLINK_CYCLES per phase, only in HOLD.
  - Phase resets to "on" at LATCH.
  - leds = leds_reg & ~(mask_reg & {WIDTH{phase_off}}).
  - Outside HOLD, the phase is forced "on".
- LM_BLINK_EN undefined: leds = leds_reg. The blink counter and mask_reg are not built. The blink_mask port stays present and is unused.

## Structure
- Package LM_pkg holds:
  - the state encoding (IDLE=2'd0, READ=2'd1, LATCH=2'd2, HOLD=2'd3);
  - SHOWN_CNT_W=16;
  - the default HOLD_CYCLES and BLINK_CYCLES constants.
- Sub-module LM_hold_timer: a load/decrement/expire down-counter of width CNT_W. It is instantiated for the hold counter, and again for blink when LM_BLINK_EN is defined.

## Test plan
- Single pop: HOLD_CYCLES=4; push 0xA5; fifo_empty falls → one rd_en pulse; leds=0xA5 two edges later and held 4 cycles; then 0x00, busy=0, shown_cnt=1.
- Back-to-back: push 0x01, 0x02, 0x03 with HOLD_CYCLES=3 → exactly 3 rd_en pulses; leds change every 5 cycles; shown_cnt=3.
- Keep-last: CLEAR_ON_EMPTY=0; push 0x3C → leds stay 0x3C indefinitely after the FIFO empties; a new push of 0x0F replaces it.
- Flush: assert flush in cycle 2 of HOLD → leds=0 and state IDLE next edge; FIFO word popped in READ discarded; shown_cnt unchanged.
- Reset: rst during READ → next edge leds=0, rd_en=0, shown_cnt=0; rst together with flush behaves as rst.
- Blink (LM_BLINK_EN, BLINK_CYCLES=2, HOLD_CYCLES=8): data 0xFF, mask 0x0F → leds 0xFF, 0xFF, 0xF0, 0xF0, 0xFF…; without the macro, leds stay 0xFF.
